xed_encoder_seq: RTL and testbench
==================================

# xed_encoder_seq

Parametrised, multi-cycle XED encoder for the memory-channel ECC path. Accepts one block of `NUM_CHIPS` chip payloads through a valid/ready handshake and produces:
- one CRC-ATM byte per chip;
- the bitwise XOR parity across all chips, split into `NUM_GROUPS` groups;
- one CRC byte over the full parity vector.

CRCs are computed by byte-serial engines over `CHIP_BYTES/BYTES_PER_CYCLE` cycles, which keeps the CRC logic small at large chip widths. Results are held under a valid/ready output handshake.

## Interface
- `NUM_CHIPS`, default 8: chips per block, ≥2.
- `CHIP_BYTES`, default 16: bytes per chip.
- `NUM_GROUPS`, default 2: parity groups. `CHIP_BYTES % NUM_GROUPS == 0`.
- `BYTES_PER_CYCLE`, default 4: bytes each CRC engine consumes per cycle. `CHIP_BYTES % BYTES_PER_CYCLE == 0`.
- Derived: `STEPS = CHIP_BYTES/BYTES_PER_CYCLE`; `GB = CHIP_BYTES/NUM_GROUPS`.

Ports (reset rst_n, asynchronous, active-low; clock clk):
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  block present on `chip_data`.
- `in_ready`  out  1  block can be accepted.
- `chip_data`  in  `NUM_CHIPS*CHIP_BYTES*8`  chip i occupies `[i*CHIP_BYTES*8 +: CHIP_BYTES*8]`.
- `out_valid`  out  1  results valid.
- `out_ready`  in  1  consumer takes results.
- `chip_crc`  out  `NUM_CHIPS*8`  CRC of chip i at `[8i +: 8]`.
- `xor_parity`  out  `CHIP_BYTES*8`  XOR of all chips; group g at `[g*GB*8 +: GB*8]`.
- `parity_crc`  out  8  CRC over `xor_parity`.
- `busy`  out  1  state ≠ IDLE.

## Operation
- CRC definition (all engines):
  - polynomial x^8+x^2+x+1 (0x07), MSB-first bit processing;
  - init 0xFF, output is the bitwise inverse of the final register;
  - bytes consumed from the most significant byte of each chip's slice down to byte 0.
- Per-byte update: `t = crc ^ byte`, then 8 iterations of `t = t[7] ? (t<<1)^0x07 : t<<1`.
- FSM states:
  - IDLE: `in_ready=1`.
  - CALC: step counter 0..STEPS-1.
  - DONE: `out_valid=1`.
- Accept (in_valid & in_ready):
  - register `chip_data` into the capture buffer;
  - compute the XOR parity combinationally from the input and register it into `xor_parity`;
  - load all NUM_CHIPS+1 accumulators with 0xFF;
  - clear the step counter and enter CALC.
- CALC, each cycle: every engine applies BYTES_PER_CYCLE byte updates from its capture slice (chip engines) or from the parity register (parity engine), starting at the byte index given by the step counter.
  - On step STEPS-1: load the inverted accumulators into `chip_crc`/`parity_crc`, enter DONE.
- DONE: outputs held stable while `out_valid & !out_ready`.
  - On out_valid & out_ready with no new input: go to IDLE.
- Back-to-back: in DONE, `in_ready = out_ready`. A simultaneous output handshake and input accept goes directly to CALC. The new parity is loaded into `xor_parity` on that same edge, after the old value has been consumed.
- `in_valid` while in CALC is ignored and not accepted. The source must hold data until `in_ready`.
- Outputs change only on an accept edge (`xor_parity`) or the final CALC edge (CRCs). Otherwise they keep their last values.

## Timing
- Reset values:
  - state IDLE; `in_ready=1`; `out_valid=0`; `busy=0`;
  - `chip_crc`, `xor_parity`, `parity_crc` all 0;
  - step counter 0.
- Latency: with the accept at edge 0, `out_valid` is high after edge STEPS (defaults: 4 cycles).
- Throughput: one block per STEPS+1 cycles with `out_ready` held high (default 5).
- `in_ready` is a combinational function of state and `out_ready` only. It never depends on `in_valid`.
- Reset asserted mid-CALC or mid-DONE:
  - immediate return to reset values;
  - the partially computed block is discarded;
  - no `out_valid` pulse after release.

## Test plan
- **Reset**: assert `rst_n=0` mid-CALC → all outputs at reset values within the reset cycle. After release: `in_ready=1`, `out_valid=0`, no spurious result.
- **All-zero block** (defaults):
  - `xor_parity=0`.
  - Every `chip_crc` byte equals `parity_crc`, and matches the bench model.
  - `out_valid` rises exactly 4 cycles after accept.
- **Single-chip block**: chip3 = 128'h00112233445566778899AABBCCDDEEFF, others 0 → `xor_parity` equals chip3 data; `parity_crc == chip_crc[31:24]`; group1 = 64'h0011223344556677.
- **Cancelling block**: chip i = {16{8'(i)}} for i=0..7 → `xor_parity=0`. Each `chip_crc` matches the model.
- **Backpressure / back-to-back**:
  - Hold `out_ready=0` for 10 cycles in DONE → outputs and `out_valid` stable, `in_ready=0`.
  - Then raise `out_ready` with a new `in_valid` → same-edge handoff, second result after 4 more cycles.
  - 100 random blocks with random `out_ready` → all results match the model, none lost or duplicated.
- **Parameter sweep**: NUM_CHIPS=4, CHIP_BYTES=32, NUM_GROUPS=4, BYTES_PER_CYCLE=8 → latency 4; random data matches the model; `busy` is high exactly during CALC and DONE.

Source files
------------

// File: rtl/xed_encoder_seq.sv
// XED encoder: per-chip CRC-8 (poly 0x07, init 0xFF, inverted result), cross-chip XOR parity
// split into groups, and a CRC over that parity, computed by byte-serial engines.
module xed_encoder_seq #(
  parameter int NUM_CHIPS       = 8,
  parameter int CHIP_BYTES      = 16,
  parameter int NUM_GROUPS      = 2,
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_CHIPS*CHIP_BYTES*8-1:0] chip_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_CHIPS*8-1:0]            chip_crc,
  output logic [CHIP_BYTES*8-1:0]           xor_parity,
  output logic [7:0]                        parity_crc,
  output logic                              busy
);

  localparam int STEPS  = CHIP_BYTES / BYTES_PER_CYCLE;
  localparam int GB     = CHIP_BYTES / NUM_GROUPS;
  localparam int DW     = CHIP_BYTES * 8;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] t;
    t = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      t = t[7] ? ((t << 1) ^ 8'h07) : (t << 1);
    end
    return t;
  endfunction

  state_t                     state_r, state_nxt_s;
  logic [STEP_W-1:0]          step_r;
  logic [NUM_CHIPS*DW-1:0]    cap_r;
  logic [DW-1:0]              xor_parity_r;
  logic [DW-1:0]              parity_s;
  logic [NUM_CHIPS*8-1:0]     chip_crc_r;
  logic [7:0]                 parity_crc_r;
  logic [7:0]                 acc_r     [NUM_CHIPS+1];
  logic [7:0]                 acc_nxt_s [NUM_CHIPS+1];
  logic [7:0]                 byte_s;
  logic                       in_ready_s, out_valid_s, busy_s;
  logic                       accept_s, last_s;

  assign accept_s = in_valid & in_ready_s;
  assign last_s   = (step_r == STEP_W'(STEPS - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a DONE handshake with a new block goes straight back to CALC.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = accept_s ? CALC : IDLE;
      CALC:    state_nxt_s = last_s ? DONE : CALC;
      DONE: begin
        if (out_ready) begin
          state_nxt_s = accept_s ? CALC : IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Handshake outputs decoded from state; in_ready never looks at in_valid.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    busy_s      = 1'b1;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
        busy_s     = 1'b0;
      end
      CALC: in_ready_s = 1'b0;
      DONE: begin
        in_ready_s  = out_ready;
        out_valid_s = 1'b1;
      end
      default: begin
        in_ready_s = 1'b0;
        busy_s     = 1'b0;
      end
    endcase
  end

  // Group-wise XOR of all chips taken directly from the input bus.
  always_comb begin
    parity_s = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      for (int c = 0; c < NUM_CHIPS; c++) begin
        parity_s[g*GB*8 +: GB*8] = parity_s[g*GB*8 +: GB*8] ^ chip_data[c*DW + g*GB*8 +: GB*8];
      end
    end
  end

  // Engines walk from the top byte down; engine NUM_CHIPS runs over the parity register.
  always_comb begin
    byte_s = 8'h00;
    for (int e = 0; e <= NUM_CHIPS; e++) begin
      acc_nxt_s[e] = acc_r[e];
    end
    for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
      for (int e = 0; e < NUM_CHIPS; e++) begin
        byte_s = 8'h00;
        for (int k = 0; k < STEPS; k++) begin
          byte_s = (step_r == STEP_W'(k)) ?
                   cap_r[e*DW + (CHIP_BYTES - 1 - (k*BYTES_PER_CYCLE + j))*8 +: 8] : byte_s;
        end
        acc_nxt_s[e] = crc8_byte(acc_nxt_s[e], byte_s);
      end
      byte_s = 8'h00;
      for (int k = 0; k < STEPS; k++) begin
        byte_s = (step_r == STEP_W'(k)) ?
                 xor_parity_r[(CHIP_BYTES - 1 - (k*BYTES_PER_CYCLE + j))*8 +: 8] : byte_s;
      end
      acc_nxt_s[NUM_CHIPS] = crc8_byte(acc_nxt_s[NUM_CHIPS], byte_s);
    end
  end

  // Capture, accumulate and publish results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_r        <= '0;
      xor_parity_r <= '0;
      step_r       <= '0;
      chip_crc_r   <= '0;
      parity_crc_r <= 8'h00;
      for (int e = 0; e <= NUM_CHIPS; e++) begin
        acc_r[e] <= 8'h00;
      end
    end else if (accept_s) begin
      cap_r        <= chip_data;
      xor_parity_r <= parity_s;
      step_r       <= '0;
      for (int e = 0; e <= NUM_CHIPS; e++) begin
        acc_r[e] <= 8'hFF;
      end
    end else if (state_r == CALC) begin
      step_r <= step_r + STEP_W'(1);
      for (int e = 0; e <= NUM_CHIPS; e++) begin
        acc_r[e] <= acc_nxt_s[e];
      end
      if (last_s) begin
        for (int e = 0; e < NUM_CHIPS; e++) begin
          chip_crc_r[8*e +: 8] <= ~acc_nxt_s[e];
        end
        parity_crc_r <= ~acc_nxt_s[NUM_CHIPS];
      end
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_s;
  assign busy       = busy_s;
  assign chip_crc   = chip_crc_r;
  assign xor_parity = xor_parity_r;
  assign parity_crc = parity_crc_r;

endmodule

// File: tb/tb_xed_encoder_seq.sv
// Directed and randomized bench for xed_encoder_seq: default build plus a
// 4-chip / 32-byte / 4-group / 8-byte-per-cycle build.
module tb_xed_encoder_seq;

  logic          clk;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, busy;
  logic [1023:0] chip_data;
  logic [63:0]   chip_crc;
  logic [127:0]  xor_parity;
  logic [7:0]    parity_crc;

  logic          in_valid2, in_ready2, out_valid2, out_ready2, busy2;
  logic [1023:0] chip_data2;
  logic [31:0]   chip_crc2;
  logic [255:0]  xor_parity2;
  logic [7:0]    parity_crc2;

  int checks = 0;
  int errors = 0;

  xed_encoder_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .chip_data(chip_data), .out_valid(out_valid), .out_ready(out_ready),
    .chip_crc(chip_crc), .xor_parity(xor_parity), .parity_crc(parity_crc), .busy(busy)
  );

  xed_encoder_seq #(
    .NUM_CHIPS(4), .CHIP_BYTES(32), .NUM_GROUPS(4), .BYTES_PER_CYCLE(8)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .chip_data(chip_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .chip_crc(chip_crc2), .xor_parity(xor_parity2), .parity_crc(parity_crc2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-serial reference CRC: bytes from nbytes-1 down to 0, MSB first.
  function automatic logic [7:0] crc_model(input logic [255:0] d, input int nbytes);
    logic [7:0] c;
    logic       fb;
    c = 8'hFF;
    for (int b = nbytes - 1; b >= 0; b--) begin
      for (int k = 7; k >= 0; k--) begin
        fb = c[7] ^ d[8*b + k];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return ~c;
  endfunction

  function automatic logic [127:0] exp_xor(input logic [1023:0] d);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 8; c++) r = r ^ d[128*c +: 128];
    return r;
  endfunction

  function automatic logic [63:0] exp_crcs(input logic [1023:0] d);
    logic [63:0] r;
    for (int c = 0; c < 8; c++) r[8*c +: 8] = crc_model({128'h0, d[128*c +: 128]}, 16);
    return r;
  endfunction

  function automatic logic [255:0] exp_xor2(input logic [1023:0] d);
    logic [255:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) r = r ^ d[256*c +: 256];
    return r;
  endfunction

  function automatic logic [31:0] exp_crcs2(input logic [1023:0] d);
    logic [31:0] r;
    for (int c = 0; c < 4; c++) r[8*c +: 8] = crc_model(d[256*c +: 256], 32);
    return r;
  endfunction

  function automatic logic [1023:0] rand_block();
    logic [1023:0] d;
    for (int w = 0; w < 32; w++) d[32*w +: 32] = $urandom();
    return d;
  endfunction

  // Offer a block; returns at accept edge + 1 with in_valid dropped.
  task automatic drive_block(input logic [1023:0] d, output bit ok);
    chip_data = d;
    in_valid  = 1'b1;
    ok        = 1'b0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drive_block2(input logic [1023:0] d, output bit ok);
    chip_data2 = d;
    in_valid2  = 1'b1;
    ok         = 1'b0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (in_ready2) begin
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid2 = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid is seen.
  task automatic wait_result(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!out_valid && cyc < 40);
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy=%b vld=%b busy=%b expected 1 0 0", in_ready, out_valid, busy);
    end
    checks++;
    if (chip_crc !== 64'h0 || xor_parity !== 128'h0 || parity_crc !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got crc=%h par=%h pcrc=%h expected all zero", chip_crc, xor_parity, parity_crc);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_ok(input bit ok, input string name);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_accept: got no accept expected accept", name);
    end
  endtask

  task automatic test_all_zero;
    bit ok;
    int cyc;
    logic [1023:0] d;
    d = '0;
    drive_block(d, ok);
    check_ok(ok, "zero");
    wait_result(cyc);
    checks++;
    if (cyc !== 4) begin
      errors++;
      $display("FAIL zero_latency: got %0d expected 4", cyc);
    end
    checks++;
    if (xor_parity !== 128'h0) begin
      errors++;
      $display("FAIL zero_parity: got %h expected 0", xor_parity);
    end
    checks++;
    if (chip_crc !== exp_crcs(d) || chip_crc !== {8{parity_crc}}) begin
      errors++;
      $display("FAIL zero_crc: got %h pcrc %h expected %h", chip_crc, parity_crc, exp_crcs(d));
    end
    checks++;
    if (parity_crc !== crc_model(256'h0, 16)) begin
      errors++;
      $display("FAIL zero_pcrc: got %h expected %h", parity_crc, crc_model(256'h0, 16));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_chip;
    bit ok;
    int cyc;
    logic [1023:0] d;
    logic [127:0]  c3;
    c3 = 128'h00112233445566778899AABBCCDDEEFF;
    d = '0;
    d[3*128 +: 128] = c3;
    drive_block(d, ok);
    check_ok(ok, "single");
    wait_result(cyc);
    checks++;
    if (cyc !== 4 || xor_parity !== c3) begin
      errors++;
      $display("FAIL single_parity: got lat %0d par %h expected 4 %h", cyc, xor_parity, c3);
    end
    checks++;
    if (xor_parity[127:64] !== 64'h0011223344556677) begin
      errors++;
      $display("FAIL single_group1: got %h expected 0011223344556677", xor_parity[127:64]);
    end
    checks++;
    if (parity_crc !== chip_crc[31:24] || parity_crc !== crc_model({128'h0, c3}, 16)) begin
      errors++;
      $display("FAIL single_pcrc: got %h chip3 %h expected %h", parity_crc, chip_crc[31:24],
               crc_model({128'h0, c3}, 16));
    end
    checks++;
    if (chip_crc !== exp_crcs(d)) begin
      errors++;
      $display("FAIL single_crc: got %h expected %h", chip_crc, exp_crcs(d));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_cancel;
    bit ok;
    int cyc;
    logic [1023:0] d;
    for (int i = 0; i < 8; i++) d[128*i +: 128] = {16{8'(i)}};
    drive_block(d, ok);
    check_ok(ok, "cancel");
    wait_result(cyc);
    checks++;
    if (cyc !== 4 || xor_parity !== 128'h0) begin
      errors++;
      $display("FAIL cancel_parity: got lat %0d par %h expected 4 0", cyc, xor_parity);
    end
    checks++;
    if (chip_crc !== exp_crcs(d) || parity_crc !== crc_model(256'h0, 16)) begin
      errors++;
      $display("FAIL cancel_crc: got %h %h expected %h %h", chip_crc, parity_crc, exp_crcs(d),
               crc_model(256'h0, 16));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    bit ok, bad;
    int cyc;
    logic [1023:0] a, b;
    a = rand_block();
    b = rand_block();
    out_ready = 1'b0;
    drive_block(a, ok);
    check_ok(ok, "bp_a");
    wait_result(cyc);
    bad = (cyc !== 4);
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || chip_crc !== exp_crcs(a) ||
          xor_parity !== exp_xor(a) || parity_crc !== crc_model({128'h0, exp_xor(a)}, 16)) bad = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_hold: got vld=%b rdy=%b crc=%h expected 1 0 %h", out_valid, in_ready,
               chip_crc, exp_crcs(a));
    end
    chip_data = b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready: got %b expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || xor_parity !== exp_xor(b) || chip_crc !== exp_crcs(a)) begin
      errors++;
      $display("FAIL b2b_handoff: got vld=%b busy=%b par=%h crc=%h expected 0 1 %h %h", out_valid,
               busy, xor_parity, chip_crc, exp_xor(b), exp_crcs(a));
    end
    wait_result(cyc);
    checks++;
    if (cyc !== 4 || chip_crc !== exp_crcs(b) || parity_crc !== crc_model({128'h0, exp_xor(b)}, 16)) begin
      errors++;
      $display("FAIL b2b_second: got lat %0d crc %h expected 4 %h", cyc, chip_crc, exp_crcs(b));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_calc;
    bit ok, bad;
    logic [1023:0] d;
    d = rand_block();
    drive_block(d, ok);
    check_ok(ok, "rst");
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_ctrl: got rdy=%b vld=%b busy=%b expected 1 0 0", in_ready, out_valid, busy);
    end
    checks++;
    if (chip_crc !== 64'h0 || xor_parity !== 128'h0 || parity_crc !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_data: got crc=%h par=%h pcrc=%h expected all zero", chip_crc, xor_parity, parity_crc);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL rst_release: got spurious activity vld=%b busy=%b expected idle", out_valid, busy);
    end
  endtask

  task automatic test_random;
    logic [63:0]  q_c[$];
    logic [127:0] q_x[$];
    logic [7:0]   q_p[$];
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    fork
      begin
        bit ok;
        logic [1023:0] d;
        for (int n = 0; n < 100; n++) begin
          d = rand_block();
          chip_data = d;
          in_valid  = 1'b1;
          ok = 1'b0;
          for (int i = 0; i < 200 && !ok; i++) begin
            #1;
            if (in_ready) begin
              q_c.push_back(exp_crcs(d));
              q_x.push_back(exp_xor(d));
              q_p.push_back(crc_model({128'h0, exp_xor(d)}, 16));
              ok = 1'b1;
            end
            @(posedge clk); #1;
          end
          in_valid = 1'b0;
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
      end
      begin
        while (got < 100 && cyc < 6000) begin
          @(posedge clk); #1;
          cyc++;
          out_ready = 1'($urandom_range(0, 1));
          #1;
          if (out_valid && out_ready) begin
            checks++;
            if (q_c.size() == 0) begin
              errors++;
              $display("FAIL rand_extra: got unexpected result %h expected none", chip_crc);
            end else begin
              if (chip_crc !== q_c[0] || xor_parity !== q_x[0] || parity_crc !== q_p[0]) begin
                errors++;
                $display("FAIL rand_result_%0d: got %h %h %h expected %h %h %h", got, chip_crc,
                         xor_parity, parity_crc, q_c[0], q_x[0], q_p[0]);
              end
              void'(q_c.pop_front());
              void'(q_x.pop_front());
              void'(q_p.pop_front());
            end
            got++;
          end
        end
      end
    join
    out_ready = 1'b1;
    checks++;
    if (got != 100 || q_c.size() != 0) begin
      errors++;
      $display("FAIL rand_count: got %0d results, %0d pending expected 100, 0", got, q_c.size());
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_sweep;
    bit ok, bad;
    int cyc;
    logic [1023:0] d;
    for (int n = 0; n < 3; n++) begin
      d = rand_block();
      bad = (busy2 !== 1'b0);
      out_ready2 = 1'b0;
      drive_block2(d, ok);
      check_ok(ok, "sweep");
      cyc = 0;
      do begin
        if (busy2 !== 1'b1) bad = 1'b1;
        @(posedge clk); #1;
        cyc++;
      end while (!out_valid2 && cyc < 40);
      checks++;
      if (cyc !== 4) begin
        errors++;
        $display("FAIL sweep_latency_%0d: got %0d expected 4", n, cyc);
      end
      checks++;
      if (chip_crc2 !== exp_crcs2(d) || xor_parity2 !== exp_xor2(d) ||
          parity_crc2 !== crc_model(exp_xor2(d), 32)) begin
        errors++;
        $display("FAIL sweep_result_%0d: got %h %h expected %h %h", n, chip_crc2, parity_crc2,
                 exp_crcs2(d), crc_model(exp_xor2(d), 32));
      end
      @(posedge clk); #1;
      if (busy2 !== 1'b1 || out_valid2 !== 1'b1) bad = 1'b1;
      out_ready2 = 1'b1;
      @(posedge clk); #1;
      if (busy2 !== 1'b0 || out_valid2 !== 1'b0) bad = 1'b1;
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL sweep_busy_%0d: got busy=%b vld=%b expected busy only in CALC/DONE", n, busy2, out_valid2);
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    chip_data  = '0;
    in_valid2  = 1'b0;
    out_ready2 = 1'b1;
    chip_data2 = '0;
    test_reset();
    test_all_zero();
    test_single_chip();
    test_cancel();
    test_back_to_back();
    test_reset_mid_calc();
    test_random();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
